cordic_cos_iter: RTL and testbench
==================================

Name: cordic_cos_iter

Overview:
- Iterative rotation-mode CORDIC engine directly downstream of the float-to-fixed converter.
- Consumes the converter's 22-bit signed fixed-point angle (radians, range [-1, 1]) and produces cos and sin in the same fixed format.
- One micro-rotation per clock, valid/ready handshake on both sides.
- Output feeds the later function-evaluation datapath.

Parameters:
- WIDTH, 22: data width of angle and results, two's complement Q2.20 (sign, 1 integer bit, 20 fraction bits).
- FRAC, 20: fraction bits. Must equal WIDTH-2.
- ITERATIONS, 16: number of micro-rotations, range 8..20.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  theta is valid.
- in_ready  out  1  block can accept theta.
- theta  in  WIDTH  angle in radians, Q2.20 (from float_to_fixed fixedPoint).
- out_valid  out  1  cos_out/sin_out valid.
- out_ready  in  1  consumer accepts result.
- cos_out  out  WIDTH  cos(theta), Q2.20.
- sin_out  out  WIDTH  sin(theta), Q2.20.

Behaviour:
- Reset: the only clock is clk. reset is synchronous and active-high, sampled on rising clk.
  - Reset gives state IDLE, in_ready=1, out_valid=0, cos_out=0, sin_out=0, iteration counter=0.
  - Reset mid-rotation or while DONE abandons the operation with no output.
- FSM states:
  - IDLE:
    - in_ready=1.
    - On in_valid: load x=K (0x09B74F = round(0.607252935*2^20)), y=0, z=clamp(theta), i=0.
    - Go to ROTATE.
  - ROTATE:
    - in_ready=0.
    - Each cycle, with d = (z>=0) ? +1 : -1:
      - x <= x - d*(y>>>i)
      - y <= y + d*(x>>>i)
      - z <= z - d*ATAN[i]
      - i <= i+1
    - After the update with i=ITERATIONS-1, go to DONE.
  - DONE:
    - out_valid=1; cos_out=x, sin_out=y, held stable until out_ready=1.
    - On out_ready, go to IDLE on the next edge.
    - in_ready=0 in DONE (no overlap).
- Latency: in_valid accepted at edge N. out_valid rises after edge N+ITERATIONS and is visible in the cycle that follows. Throughput is one result per ITERATIONS+2 cycles minimum.
- Clamp: theta > +1.0 (0x100000) is replaced by 0x100000. theta < -1.0 (0x300000) is replaced by 0x300000. Both ends are within CORDIC convergence (±1.743 rad).
- Arithmetic:
  - x, y, z datapath is WIDTH+2 bits internally (2 guard MSBs, sign-extended), so K-scaled growth never overflows.
  - >>> is an arithmetic shift.
  - Outputs are truncated back to WIDTH. |cos|,|sin| <= 1.0 always fits Q2.20.
- ATAN[i] = round(atan(2^-i)*2^20), e.g. ATAN[0]=823550, ATAN[1]=486170, ATAN[2]=256879.
- Accuracy: |error| <= 64 LSB versus the ideal value for ITERATIONS=16.
- in_valid while not in IDLE is ignored; the upstream holds it because in_ready=0.
- out_ready while not in DONE has no effect.

Decomposition:
- Package cordic_pkg contains:
  - WIDTH and FRAC defaults.
  - CORDIC_K constant.
  - The ATAN table as a constant array of 20 entries.
  - The FSM state encoding (IDLE, ROTATE, DONE).
- One sub-module, cordic_atan_lut: combinational index to ATAN[i], sized by WIDTH/FRAC. It keeps the table reusable by a future pipelined variant.

Test Plan:
- Angle 0: theta=0x000000 with in_valid pulse -> out_valid after 16+1 cycles; cos_out≈1048576 (0x100000) ±64, sin_out≈0 ±64.
- Angle 0.77: theta=0x0C51EB -> cos_out≈752784 ±64, sin_out≈729950 ±64.
- Angle -0.07: theta=0x3EE148 -> cos_out≈1046008 ±64, sin_out≈-73341 ±64.
- Angle -1 and clamp:
  - theta=0x300000 -> cos_out≈566546, sin_out≈-882344 (±64).
  - Then theta=0x180000 (+1.5) -> result equals the theta=+1.0 result (cos≈566546, sin≈+882344).
- Backpressure: hold out_ready=0 for 10 cycles in DONE -> out_valid stays 1, outputs stable, in_ready=0. Second in_valid during this window is not accepted; it is accepted one cycle after out_ready handshake.
- Reset mid-operation: assert reset at rotation cycle 5 -> next cycle in_ready=1, out_valid=0, outputs 0. A new theta=0x000000 then completes normally with cos≈0x100000.

Source files
------------

// File: rtl/cordic_pkg.sv
// Shared constants, arctangent table and FSM encoding for the iterative CORDIC engine.
package cordic_pkg;

  localparam int DEFAULT_WIDTH = 22;
  localparam int DEFAULT_FRAC  = 20;

  // Table and gain constants are stored at this fraction precision.
  localparam int TABLE_FRAC   = 20;
  localparam int ATAN_ENTRIES = 20;
  localparam int ITER_W       = 5;

  localparam int CORDIC_K = 636751;  // 0x09B74F, round(0.607252935 * 2^20)

  localparam int ATAN_TABLE [ATAN_ENTRIES] = '{
    823550, 486170, 256879, 130396, 65451, 32757, 16383, 8192, 4096, 2048,
    1024,   512,    256,    128,    64,    32,    16,    8,    4,    2
  };

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ROTATE = 2'd1,
    DONE   = 2'd2
  } stateT;

  // Rescale a TABLE_FRAC constant to the requested fraction width.
  function automatic int scaleFrac(input int value, input int frac);
    if (frac >= TABLE_FRAC) return value <<< (frac - TABLE_FRAC);
    else                    return value >>> (TABLE_FRAC - frac);
  endfunction

endpackage

// File: rtl/cordic_atan_lut.sv
// Combinational arctangent lookup, atan(2^-idx) in the engine's fixed-point format.
module cordic_atan_lut
  import cordic_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int FRAC  = DEFAULT_FRAC
) (
  input  logic [ITER_W-1:0] idx,
  output logic [WIDTH+1:0]  atanVal
);

  localparam int DW = WIDTH + 2;

  // NOTE: a default assignment ahead of the branch keeps this block free of latches.
  always_comb begin
    atanVal = '0;
    if (int'(idx) < ATAN_ENTRIES) atanVal = DW'(scaleFrac(ATAN_TABLE[idx], FRAC));
  end

endmodule

// File: rtl/cordic_cos_iter.sv
// Iterative rotation-mode CORDIC: one micro-rotation per clock, producing cos/sin of a clamped angle.
module cordic_cos_iter
  import cordic_pkg::*;
#(
  parameter int WIDTH      = DEFAULT_WIDTH,
  parameter int FRAC       = DEFAULT_FRAC,
  parameter int ITERATIONS = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] theta,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] cos_out,
  output logic [WIDTH-1:0] sin_out
);

  // Two guard MSBs absorb the CORDIC gain growth before truncation back to WIDTH.
  localparam int DW = WIDTH + 2;
  localparam logic signed [DW-1:0] POS_ONE = DW'(scaleFrac(1 << TABLE_FRAC, FRAC));
  localparam logic signed [DW-1:0] NEG_ONE = -POS_ONE;
  localparam logic signed [DW-1:0] K_INIT  = DW'(scaleFrac(CORDIC_K, FRAC));
  localparam logic [ITER_W-1:0]    LAST_ITER = ITER_W'(ITERATIONS - 1);

  stateT                   state;
  logic signed [DW-1:0]    xReg, yReg, zReg;
  logic [ITER_W-1:0]       iter;

  logic signed [DW-1:0]    thetaExt, thetaClamped;
  logic signed [DW-1:0]    xShift, yShift;
  logic signed [DW-1:0]    nextX, nextY, nextZ;
  logic signed [DW-1:0]    atanVal;

  cordic_atan_lut #(
    .WIDTH (WIDTH),
    .FRAC  (FRAC)
  ) atanLut (
    .idx     (iter),
    .atanVal (atanVal)
  );

  always_comb begin
    thetaExt     = {{2{theta[WIDTH-1]}}, theta};
    thetaClamped = thetaExt;
    if (thetaExt > POS_ONE)      thetaClamped = POS_ONE;
    else if (thetaExt < NEG_ONE) thetaClamped = NEG_ONE;
  end

  // Rotation direction follows the sign of the residual angle.
  always_comb begin
    xShift = xReg >>> iter;
    yShift = yReg >>> iter;
    if (!zReg[DW-1]) begin
      nextX = xReg - yShift;
      nextY = yReg + xShift;
      nextZ = zReg - atanVal;
    end else begin
      nextX = xReg + yShift;
      nextY = yReg - xShift;
      nextZ = zReg + atanVal;
    end
  end

  // NOTE: state registers use non-blocking assignments so every update sees pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: the datapath registers are cleared too so an abandoned rotation leaves no residue.
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      cos_out   <= '0;
      sin_out   <= '0;
      xReg      <= '0;
      yReg      <= '0;
      zReg      <= '0;
      iter      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            xReg     <= K_INIT;
            yReg     <= '0;
            zReg     <= thetaClamped;
            iter     <= '0;
            in_ready <= 1'b0;
            state    <= ROTATE;
          end
        end
        ROTATE: begin
          xReg <= nextX;
          yReg <= nextY;
          zReg <= nextZ;
          iter <= iter + 1'b1;
          if (iter == LAST_ITER) begin
            cos_out   <= nextX[WIDTH-1:0];
            sin_out   <= nextY[WIDTH-1:0];
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cordic_cos_iter.sv
// Directed self-checking bench for cordic_cos_iter: angles, clamp, backpressure and reset recovery.
module tb_cordic_cos_iter;

  localparam int WIDTH = 22;
  localparam int ITERS = 16;
  localparam int TOL   = 64;
  localparam int LIMIT = 100;

  logic             clk;
  logic             reset;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] theta;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] cos_out;
  logic [WIDTH-1:0] sin_out;

  int checks = 0;
  int errors = 0;

  localparam logic [WIDTH-1:0] ANG_THETA [4] = '{22'h000000, 22'h0C51EB, 22'h3EE148, 22'h300000};
  localparam int               ANG_COS   [4] = '{1048576, 752784, 1046008, 566546};
  localparam int               ANG_SIN   [4] = '{0, 729950, -73341, -882344};

  cordic_cos_iter #(.WIDTH(WIDTH), .FRAC(20), .ITERATIONS(ITERS)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .theta     (theta),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .cos_out   (cos_out),
    .sin_out   (sin_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int sval(input logic [WIDTH-1:0] v);
    return int'($signed(v));
  endfunction

  function automatic int absDiff(input int a, input int b);
    return (a > b) ? a - b : b - a;
  endfunction

  task automatic startOp(input logic [WIDTH-1:0] t);
    theta    = t;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
  endtask

  task automatic waitDone(output int cycles);
    cycles = 0;
    while (!out_valid && cycles < LIMIT) begin
      step();
      cycles++;
    end
  endtask

  task automatic handshake();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    checks++;
    if (cos_out !== '0) begin errors++; $display("FAIL reset_cos got %h want 0", cos_out); end
    checks++;
    if (sin_out !== '0) begin errors++; $display("FAIL reset_sin got %h want 0", sin_out); end
  endtask

  task automatic test_angles();
    int lat;
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (in_ready !== 1'b1) begin errors++; $display("FAIL angle%0d_ready got %b want 1", k, in_ready); end
      startOp(ANG_THETA[k]);
      waitDone(lat);
      checks++;
      if (lat != ITERS) begin errors++; $display("FAIL angle%0d_latency got %0d want %0d", k, lat, ITERS); end
      checks++;
      if (absDiff(sval(cos_out), ANG_COS[k]) > TOL)
        begin errors++; $display("FAIL angle%0d_cos got %0d want %0d+-%0d", k, sval(cos_out), ANG_COS[k], TOL); end
      checks++;
      if (absDiff(sval(sin_out), ANG_SIN[k]) > TOL)
        begin errors++; $display("FAIL angle%0d_sin got %0d want %0d+-%0d", k, sval(sin_out), ANG_SIN[k], TOL); end
      handshake();
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1)
        begin errors++; $display("FAIL angle%0d_release got valid=%b ready=%b want 0/1", k, out_valid, in_ready); end
    end
  endtask

  task automatic test_clamp();
    int lat;
    logic [WIDTH-1:0] refCos, refSin;
    startOp(22'h100000);
    waitDone(lat);
    refCos = cos_out;
    refSin = sin_out;
    checks++;
    if (absDiff(sval(refCos), 566546) > TOL || absDiff(sval(refSin), 882344) > TOL)
      begin errors++; $display("FAIL clamp_plus1 got %0d/%0d want 566546/882344", sval(refCos), sval(refSin)); end
    handshake();
    startOp(22'h180000);
    waitDone(lat);
    checks++;
    if (lat != ITERS || cos_out !== refCos || sin_out !== refSin)
      begin errors++; $display("FAIL clamp_plus1p5 got %h/%h lat %0d want %h/%h lat %0d", cos_out, sin_out, lat, refCos, refSin, ITERS); end
    handshake();
    startOp(22'h300000);
    waitDone(lat);
    refCos = cos_out;
    refSin = sin_out;
    handshake();
    startOp(22'h200000);
    waitDone(lat);
    checks++;
    if (cos_out !== refCos || sin_out !== refSin || absDiff(sval(sin_out), -882344) > TOL)
      begin errors++; $display("FAIL clamp_minus2 got %h/%h want %h/%h", cos_out, sin_out, refCos, refSin); end
    handshake();
  endtask

  task automatic test_backpressure();
    int lat;
    logic [WIDTH-1:0] heldCos, heldSin;
    startOp(22'h0C51EB);
    waitDone(lat);
    heldCos  = cos_out;
    heldSin  = sin_out;
    theta    = 22'h000000;
    in_valid = 1'b1;
    for (int c = 0; c < 10; c++) begin
      step();
      checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || cos_out !== heldCos || sin_out !== heldSin)
        begin errors++; $display("FAIL bp_hold%0d got v=%b r=%b %h/%h want v=1 r=0 %h/%h", c, out_valid, in_ready, cos_out, sin_out, heldCos, heldSin); end
    end
    handshake();
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1)
      begin errors++; $display("FAIL bp_after_hs got v=%b r=%b want v=0 r=1", out_valid, in_ready); end
    step();
    in_valid = 1'b0;
    checks++;
    if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_accept got ready=%b want 0", in_ready); end
    waitDone(lat);
    checks++;
    if (lat != ITERS || absDiff(sval(cos_out), 1048576) > TOL || absDiff(sval(sin_out), 0) > TOL)
      begin errors++; $display("FAIL bp_second got %0d/%0d lat %0d want 1048576/0 lat %0d", sval(cos_out), sval(sin_out), lat, ITERS); end
    handshake();
  endtask

  task automatic test_reset_mid();
    int lat;
    startOp(22'h0C51EB);
    for (int c = 0; c < 5; c++) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || cos_out !== '0 || sin_out !== '0)
      begin errors++; $display("FAIL midreset_state got r=%b v=%b %h/%h want r=1 v=0 0/0", in_ready, out_valid, cos_out, sin_out); end
    for (int c = 0; c < ITERS + 2; c++) step();
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL midreset_no_output got v=%b want 0", out_valid); end
    startOp(22'h000000);
    waitDone(lat);
    checks++;
    if (lat != ITERS || absDiff(sval(cos_out), 1048576) > TOL || absDiff(sval(sin_out), 0) > TOL)
      begin errors++; $display("FAIL midreset_recover got %0d/%0d lat %0d want 1048576/0 lat %0d", sval(cos_out), sval(sin_out), lat, ITERS); end
    handshake();
  endtask

  initial begin
    reset     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    theta     = '0;
    test_reset();
    test_angles();
    test_clamp();
    test_backpressure();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
